// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pixel types and small helpers for the image fetcher.
package vga_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] H_TOTAL  = 10'd800;
    localparam logic [9:0] V_TOTAL  = 10'd525;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam rgb12_t RGB_BLACK = 12'h000;

    // Position qualifiers that ride alongside the ROM read.
    typedef struct packed {
        logic       active;
        logic       in_img;
        logic [9:0] col;
        logic [9:0] row;
    } pix_qual_t;

    // True when a signed offset from the image origin lies inside [0, span).
    function automatic logic in_span(input logic signed [10:0] d,
                                     input logic signed [10:0] span);
        return (d >= 11'sd0) && (d < span);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register, cleared to zero by asynchronous reset.
module vga_delay_line #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift the word one stage per clock; all stages clear on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_image_fetcher.sv
// Maps the controller's scan position onto a scaled, scrolling image held in
// ROM and produces the aligned RGB pixel plus its position qualifiers.
module vga_image_fetcher
    import vga_pkg::*;
#(
    parameter int          IMG_W      = 64,
    parameter int          IMG_H      = 64,
    parameter int          ADDR_W     = 12,
    parameter int          SCALE_LOG2 = 1,
    parameter int          ORIGIN_X   = 256,
    parameter int          ORIGIN_Y   = 176,
    parameter logic [11:0] BORDER_RGB = 12'h00F,
    parameter int          ROM_LAT    = 1
) (
    input  logic              clk25M,
    input  logic              reset,
    input  logic [9:0]        col_in,
    input  logic [9:0]        row_in,
    input  logic              scroll_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_q,
    output logic [11:0]       rgb_out,
    output logic [9:0]        col_out,
    output logic [9:0]        row_out,
    output logic              active_out,
    output logic              frame_tick
);

    localparam int X_W    = $clog2(IMG_W);
    localparam int Y_W    = $clog2(IMG_H);
    localparam int SPAN_X = IMG_W << SCALE_LOG2;
    localparam int SPAN_Y = IMG_H << SCALE_LOG2;

    localparam logic signed [10:0] X_LO   = 11'(ORIGIN_X);
    localparam logic signed [10:0] Y_LO   = 11'(ORIGIN_Y);
    localparam logic signed [10:0] X_SPAN = 11'(SPAN_X);
    localparam logic signed [10:0] Y_SPAN = 11'(SPAN_Y);

    // Reject configurations that cannot be addressed or do not fit on screen.
    if (ORIGIN_X + SPAN_X > int'(H_ACTIVE) || ORIGIN_Y + SPAN_Y > int'(V_ACTIVE)) begin : g_fit_chk
        $error("vga_image_fetcher: scaled image does not fit inside the active area");
    end
    if (IMG_W * IMG_H != (1 << ADDR_W) || X_W + Y_W != ADDR_W) begin : g_addr_chk
        $error("vga_image_fetcher: IMG_W*IMG_H must equal 2**ADDR_W");
    end
    if (ROM_LAT < 1) begin : g_lat_chk
        $error("vga_image_fetcher: ROM_LAT must be at least 1");
    end

    logic signed [10:0] dx_s;
    logic signed [10:0] dy_s;
    logic               active_s;
    logic               in_img_s;
    logic [X_W-1:0]     x_s;
    logic [Y_W-1:0]     y_s;
    logic [ADDR_W-1:0]  rom_addr_d;
    logic [ADDR_W-1:0]  rom_addr_q;

    logic               frame_tick_d;
    logic               frame_tick_q;
    logic [X_W-1:0]     scroll_x_d;
    logic [X_W-1:0]     scroll_x_q;

    pix_qual_t          qual_a_s;
    pix_qual_t          qual_dly_s;
    logic [$bits(pix_qual_t)-1:0] qual_dly_raw_s;

    rgb12_t             rgb_d;
    rgb12_t             rgb_q;
    logic [9:0]         col_q;
    logic [9:0]         row_q;
    logic               active_q;

    // Stage A: classify the scan position and derive the texel coordinate.
    always_comb begin
        dx_s     = $signed({1'b0, col_in}) - X_LO;
        dy_s     = $signed({1'b0, row_in}) - Y_LO;
        active_s = (col_in < H_ACTIVE) && (row_in < V_ACTIVE);
        in_img_s = in_span(dx_s, X_SPAN) && in_span(dy_s, Y_SPAN);
        x_s      = X_W'(dx_s >>> SCALE_LOG2) + scroll_x_q;
        y_s      = Y_W'(dy_s >>> SCALE_LOG2);
        if (in_img_s) begin
            rom_addr_d = {y_s, x_s};
        end else begin
            rom_addr_d = rom_addr_q;
        end
        qual_a_s.active = active_s;
        qual_a_s.in_img = in_img_s;
        qual_a_s.col    = col_in;
        qual_a_s.row    = row_in;
    end

    // ROM address register; holds outside the image so the bus stays quiet.
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            rom_addr_q <= {ADDR_W{1'b0}};
        end else begin
            rom_addr_q <= rom_addr_d;
        end
    end

    // Next-state for the vblank pulse and the per-frame scroll offset.
    always_comb begin
        frame_tick_d = (col_in == 10'd0) && (row_in == V_ACTIVE);
        if (frame_tick_q && scroll_en) begin
            scroll_x_d = scroll_x_q + {{(X_W-1){1'b0}}, 1'b1};
        end else begin
            scroll_x_d = scroll_x_q;
        end
    end

    // Vblank pulse and scroll counter; scroll only moves at vblank start.
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            frame_tick_q <= 1'b0;
            scroll_x_q   <= {X_W{1'b0}};
        end else begin
            frame_tick_q <= frame_tick_d;
            scroll_x_q   <= scroll_x_d;
        end
    end

    // The qualifiers wait ROM_LAT cycles so they meet the ROM data.
    vga_delay_line #(
        .WIDTH ($bits(pix_qual_t)),
        .DEPTH (ROM_LAT)
    ) u_qual_dly (
        .clk_i (clk25M),
        .rst_i (reset),
        .d_i   (qual_a_s),
        .q_o   (qual_dly_raw_s)
    );

    assign qual_dly_s = pix_qual_t'(qual_dly_raw_s);

    // Output colour select: image texel, border colour or black.
    always_comb begin
        if (qual_dly_s.active && qual_dly_s.in_img) begin
            rgb_d = rgb12_t'(rom_q);
        end else if (qual_dly_s.active) begin
            rgb_d = rgb12_t'(BORDER_RGB);
        end else begin
            rgb_d = RGB_BLACK;
        end
    end

    // Output register stage: colour and its aligned position qualifiers.
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            rgb_q    <= RGB_BLACK;
            col_q    <= 10'd0;
            row_q    <= 10'd0;
            active_q <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            col_q    <= qual_dly_s.col;
            row_q    <= qual_dly_s.row;
            active_q <= qual_dly_s.active;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign frame_tick = frame_tick_q;
    assign rgb_out    = rgb_q;
    assign col_out    = col_q;
    assign row_out    = row_q;
    assign active_out = active_q;

endmodule

// File: tb/tb_vga_image_fetcher.sv
// Self-checking bench for vga_image_fetcher: fixed vectors, scroll/reset
// sequences and random scan positions against a behavioural model.
module tb_vga_image_fetcher;

    logic        clk25M;
    logic        reset;
    logic [9:0]  col_in;
    logic [9:0]  row_in;
    logic        scroll_en;
    logic [11:0] rom_addr;
    logic [11:0] rom_q;
    logic [11:0] rgb_out;
    logic [9:0]  col_out;
    logic [9:0]  row_out;
    logic        active_out;
    logic        frame_tick;

    int n_cmp  = 0;
    int n_fail = 0;

    vga_image_fetcher dut (
        .clk25M     (clk25M),
        .reset      (reset),
        .col_in     (col_in),
        .row_in     (row_in),
        .scroll_en  (scroll_en),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .rgb_out    (rgb_out),
        .col_out    (col_out),
        .row_out    (row_out),
        .active_out (active_out),
        .frame_tick (frame_tick)
    );

    // ROM whose content equals its address; read data follows the address register.
    assign rom_q = rom_addr;

    initial clk25M = 1'b0;
    always #10 clk25M = ~clk25M;

    typedef struct {
        int rgb;
        int col;
        int row;
        bit act;
    } exp_t;

    typedef struct {
        int col;
        int row;
        bit chk_addr;
        int addr;
        int rgb;
        bit act;
    } vec_t;

    // Behavioural model state
    int   scroll_m;
    bit   tick_m;
    int   addr_m;
    exp_t stage_m;
    exp_t out_m;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        scroll_m = 0;
        tick_m   = 1'b0;
        addr_m   = 0;
        stage_m  = '{rgb: 0, col: 0, row: 0, act: 1'b0};
        out_m    = '{rgb: 0, col: 0, row: 0, act: 1'b0};
    endtask

    // One pixel clock: drive inputs, predict from the spec's arithmetic, check all outputs.
    task automatic cycle(input int c, input int r, input bit en);
        exp_t p;
        int   x;
        int   y;
        int   a;
        bit   act;
        bit   img;
        bit   tick_n;
        int   scroll_n;
        col_in    = 10'(c);
        row_in    = 10'(r);
        scroll_en = en;
        act = (c < 640) && (r < 480);
        img = (c >= 256) && (c < 384) && (r >= 176) && (r < 304);
        a   = addr_m;
        if (img) begin
            x = (((c - 256) / 2) + scroll_m) % 64;
            y = (r - 176) / 2;
            a = y * 64 + x;
        end
        p.col = c;
        p.row = r;
        p.act = act;
        p.rgb = !act ? 0 : (img ? a : 'h00F);
        tick_n   = (c == 0) && (r == 480);
        scroll_n = (tick_m && en) ? (scroll_m + 1) % 64 : scroll_m;
        @(posedge clk25M);
        #1;
        addr_m   = a;
        tick_m   = tick_n;
        scroll_m = scroll_n;
        out_m    = stage_m;
        stage_m  = p;
        chk("rom_addr",   32'(rom_addr),   32'(addr_m));
        chk("frame_tick", 32'(frame_tick), 32'(tick_m));
        chk("rgb_out",    32'(rgb_out),    32'(out_m.rgb));
        chk("col_out",    32'(col_out),    32'(out_m.col));
        chk("row_out",    32'(row_out),    32'(out_m.row));
        chk("active_out", 32'(active_out), 32'(out_m.act));
        @(negedge clk25M);
    endtask

    // Hold one position for two clocks and compare address and colour with constants.
    task automatic px_check(input string nm, input int c, input int r, input int exp_addr);
        cycle(c, r, 1'b0);
        cycle(c, r, 1'b0);
        chk({nm, "_addr"}, 32'(rom_addr), 32'(exp_addr));
        chk({nm, "_rgb"},  32'(rgb_out),  32'(exp_addr));
    endtask

    // One vblank start followed by the cycle where the scroll enable is sampled.
    task automatic vtick(input bit en);
        cycle(0, 480, en);
        chk("tick_pulse", 32'(frame_tick), 32'd1);
        cycle(1, 480, en);
        chk("tick_width", 32'(frame_tick), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        reset     = 1'b1;
        col_in    = 10'd0;
        row_in    = 10'd0;
        scroll_en = 1'b0;
        model_reset();

        vecs[0] = '{col: 256, row: 176, chk_addr: 1'b1, addr: 'h000, rgb: 'h000, act: 1'b1};
        vecs[1] = '{col: 383, row: 303, chk_addr: 1'b1, addr: 'hFFF, rgb: 'hFFF, act: 1'b1};
        vecs[2] = '{col: 257, row: 176, chk_addr: 1'b1, addr: 'h000, rgb: 'h000, act: 1'b1};
        vecs[3] = '{col: 300, row: 200, chk_addr: 1'b1, addr: 'h316, rgb: 'h316, act: 1'b1};
        vecs[4] = '{col: 255, row: 200, chk_addr: 1'b1, addr: 'h316, rgb: 'h00F, act: 1'b1};
        vecs[5] = '{col: 384, row: 200, chk_addr: 1'b1, addr: 'h316, rgb: 'h00F, act: 1'b1};
        vecs[6] = '{col: 700, row: 10,  chk_addr: 1'b0, addr: 0,     rgb: 'h000, act: 1'b0};
        vecs[7] = '{col: 639, row: 479, chk_addr: 1'b0, addr: 0,     rgb: 'h00F, act: 1'b1};
        vecs[8] = '{col: 799, row: 524, chk_addr: 1'b0, addr: 0,     rgb: 'h000, act: 1'b0};
        vecs[9] = '{col: 640, row: 0,   chk_addr: 1'b0, addr: 0,     rgb: 'h000, act: 1'b0};

        // Reset state
        @(negedge clk25M);
        chk("rst_addr",   32'(rom_addr),   32'd0);
        chk("rst_rgb",    32'(rgb_out),    32'd0);
        chk("rst_col",    32'(col_out),    32'd0);
        chk("rst_row",    32'(row_out),    32'd0);
        chk("rst_active", 32'(active_out), 32'd0);
        chk("rst_tick",   32'(frame_tick), 32'd0);
        reset = 1'b0;

        // Fixed vectors with scroll at zero
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].col, vecs[i].row, 1'b0);
            cycle(vecs[i].col, vecs[i].row, 1'b0);
            if (vecs[i].chk_addr) begin
                chk("tbl_addr", 32'(rom_addr), 32'(vecs[i].addr));
            end
            chk("tbl_rgb", 32'(rgb_out),    32'(vecs[i].rgb));
            chk("tbl_act", 32'(active_out), 32'(vecs[i].act));
            chk("tbl_col", 32'(col_out),    32'(vecs[i].col));
            chk("tbl_row", 32'(row_out),    32'(vecs[i].row));
        end

        // One enabled tick scrolls by one texel, with wrap at the right edge
        vtick(1'b1);
        px_check("scroll1", 256, 176, 'h001);
        px_check("scroll1_wrap", 382, 176, 'h000);

        // Disabled ticks leave the scroll untouched
        for (int i = 0; i < 5; i++) begin
            vtick(1'b0);
        end
        px_check("scroll_hold", 256, 176, 'h001);

        // 63 more enabled ticks bring the scroll back to zero
        for (int i = 0; i < 63; i++) begin
            vtick(1'b1);
        end
        px_check("scroll_wrap64", 256, 176, 'h000);
        px_check("scroll_wrap64_far", 383, 303, 'hFFF);

        // Random scan positions with occasional vblank starts
        for (int i = 0; i < 2000; i++) begin
            int c;
            int r;
            bit en;
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                c = 0;
                r = 480;
            end else if ($urandom_range(0, 1) == 0) begin
                c = $urandom_range(240, 400);
                r = $urandom_range(160, 320);
            end else begin
                c = $urandom_range(0, 850);
                r = $urandom_range(0, 540);
            end
            cycle(c, r, en);
        end

        // Ensure a non-zero scroll before the mid-line reset
        vtick(1'b1);
        cycle(300, 200, 1'b0);
        cycle(300, 200, 1'b0);
        #5;
        reset = 1'b1;
        #1;
        chk("midrst_rgb",    32'(rgb_out),    32'd0);
        chk("midrst_active", 32'(active_out), 32'd0);
        chk("midrst_addr",   32'(rom_addr),   32'd0);
        chk("midrst_col",    32'(col_out),    32'd0);
        chk("midrst_tick",   32'(frame_tick), 32'd0);
        @(negedge clk25M);
        reset = 1'b0;
        model_reset();
        cycle(300, 200, 1'b0);
        chk("post_rst_addr1", 32'(rom_addr), 32'h316);
        chk("post_rst_rgb1",  32'(rgb_out),  32'd0);
        cycle(300, 200, 1'b0);
        chk("post_rst_rgb2",  32'(rgb_out),  32'h316);
        px_check("post_rst_scroll0", 256, 176, 'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_image_fetcher.md
Name: vga_image_fetcher

Overview:
Pixel-source stage feeding the VGA controller's R/G/B inputs. Takes the controller's current COL/ROW and computes the image ROM address. It can place a scaled, horizontally scrolling 64x64 image anywhere in the 640x480 active area. It pipelines the position and blanking qualifiers to match ROM read latency, then muxes ROM data, border colour or black onto the 12-bit RGB output.

Parameters:
IMG_W, 64, image width in texels (power of 2)
IMG_H, 64, image height in texels (power of 2)
ADDR_W, 12, ROM address width; IMG_W*IMG_H must equal 2**ADDR_W
SCALE_LOG2, 1, each texel drawn as 2**SCALE_LOG2 square pixels
ORIGIN_X, 256, first screen column of image
ORIGIN_Y, 176, first screen row of image
BORDER_RGB, 12'h00F, colour for active pixels outside the image
ROM_LAT, 1, ROM cycles from address register to valid q

Ports:
clk25M  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
col_in  in  10  current column from controller (0..799)
row_in  in  10  current row from controller (0..524)
scroll_en  in  1  enables per-frame horizontal scroll
rom_addr  out  ADDR_W  registered ROM address
rom_q  in  12  ROM data {R,G,B}, valid ROM_LAT cycles after rom_addr
rgb_out  out  12  {R[3:0],G[3:0],B[3:0]} to controller
col_out  out  10  col_in delayed to align with rgb_out
row_out  out  10  row_in delayed to align with rgb_out
active_out  out  1  rgb_out belongs to the 640x480 active area
frame_tick  out  1  one-cycle pulse at start of vertical blanking

Behaviour:
- Reset (async, immediate): rom_addr=0, rgb_out=0, col_out=0, row_out=0, active_out=0, frame_tick=0, scroll_x=0, all pipeline valids=0.
- Stage A (edge k), from col_in/row_in:
  - active = col_in<640 && row_in<480.
  - in_img = col_in in [ORIGIN_X, ORIGIN_X+(IMG_W<<SCALE_LOG2)) && row_in in [ORIGIN_Y, ORIGIN_Y+(IMG_H<<SCALE_LOG2)).
  - x = ((col_in-ORIGIN_X)>>SCALE_LOG2 + scroll_x) mod IMG_W; y = (row_in-ORIGIN_Y)>>SCALE_LOG2.
  - rom_addr <= {y,x} when in_img; otherwise rom_addr holds its previous value. This avoids needless toggling.
- Qualifiers active, in_img, col, row travel through a delay line of 1+ROM_LAT stages.
- Output stage (edge k+1+ROM_LAT):
  - rgb_out = rom_q if active&&in_img; BORDER_RGB if active&&!in_img; 12'h000 otherwise.
  - Total latency col_in -> rgb_out = 1+ROM_LAT cycles (2 at default).
  - col_out/row_out/active_out are aligned with rgb_out.
- Subtraction uses 11-bit signed intermediates; negative results are never used because in_img gates them.
- frame_tick: registered one-cycle pulse the edge after col_in==0 && row_in==480.
- scroll_x: log2(IMG_W)-bit counter, increments when frame_tick && scroll_en; wraps 63->0. Updates only at the start of vertical blanking, so no tearing.
- scroll_en low: scroll_x holds.
- col_in>=800 or row_in>=525 (out of range): treated as inactive, black.
- Reset mid-frame: outputs black at once. The first valid rgb_out appears 1+ROM_LAT cycles after reset deassert and the first qualifying pixel; scroll restarts at 0.
- Elaboration checks: image fits inside 640x480; IMG_W*IMG_H==2**ADDR_W.

Decomposition:
- Package vga_pkg holds:
  - timing constants: H_ACTIVE=640, V_ACTIVE=480, H_TOTAL=800, V_TOTAL=525;
  - typedef rgb12_t (packed struct r,g,b [3:0]);
  - constant RGB_BLACK.
- Sub-module vga_delay_line: parameterised width/depth shift register with async reset to 0. It carries {active,in_img,col,row}.

Test Plan:
- Corner texel: ROM model returns addr-derived data (q = addr). scroll_x=0, drive col=256,row=176 -> rom_addr=0x000 after 1 edge; rgb_out=0x000, active_out=1, col_out=256 after 2 edges.
- Far corner: col=383,row=303 -> rom_addr=0xFFF, rgb_out=0xFFF. Scaling: col=257 gives the same address as col=256.
- Border and blank: col=255,row=200 -> rgb_out=0x00F. col=384,row=200 -> 0x00F. col=700,row=10 -> 0x000 with active_out=0.
- Scroll: scroll_en=1, one frame_tick (row=480,col=0) -> col=256,row=176 gives addr 0x001; col=382 gives addr 0x000 (wrap). After 64 ticks scroll_x=0 again.
- Scroll hold: scroll_en=0, 5 frame_ticks -> addresses unchanged. frame_tick is exactly 1 cycle wide, once per frame.
- Reset mid-line at col=300,row=200: rgb_out=0, active_out=0, scroll_x=0 immediately (before next edge). After release, correct ROM pixel at exactly 2-cycle latency.
